// File: rtl/bf_mem_arbiter_pkg.sv
// bf_mem_arbiter_pkg: shared encodings for the unified-memory arbiter.
// These are the arbiter FSM state encodings, the memory/client direction
// encodings and the grant encoding used by the pick logic and last_grant.
package bf_mem_arbiter_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic DIRECTION_READ  = 1'b0;
    localparam logic DIRECTION_WRITE = 1'b1;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {
        ARB_STATE_IDLE    = 2'd0,
        ARB_STATE_MEM_REQ = 2'd1,
        ARB_STATE_MEM_REL = 2'd2,
        ARB_STATE_CLI_ACK = 2'd3
    } arb_state_t;

endpackage

// File: rtl/bf_mem_arbiter_if.sv
// bf_mem_arbiter_if: fetch, data and memory four-phase handshakes bundled together.
// The master modport is the arbiter's view. It serves both clients and masters
// the memory. The slave modport is the view of the CPU and memory around it.
interface bf_mem_arbiter_if #(
    parameter int i_addr_width = 16,
    parameter int d_addr_width = 8,
    parameter int m_addr_width = 17
);
    logic                                    i_req;
    logic [i_addr_width-1:0]                 i_addr;
    logic                                    i_ack;
    logic [bf_mem_arbiter_pkg::DATA_WIDTH-1:0] i_rdata;

    logic                                    d_req;
    logic                                    d_dir;
    logic [d_addr_width-1:0]                 d_addr;
    logic [bf_mem_arbiter_pkg::DATA_WIDTH-1:0] d_wdata;
    logic                                    d_ack;
    logic [bf_mem_arbiter_pkg::DATA_WIDTH-1:0] d_rdata;

    logic                                    m_req;
    logic                                    m_dir;
    logic [m_addr_width-1:0]                 m_addr;
    logic [bf_mem_arbiter_pkg::DATA_WIDTH-1:0] m_wdata;
    logic                                    m_ack;
    logic [bf_mem_arbiter_pkg::DATA_WIDTH-1:0] m_rdata;

    modport master (
        input  i_req, i_addr,
        output i_ack, i_rdata,
        input  d_req, d_dir, d_addr, d_wdata,
        output d_ack, d_rdata,
        output m_req, m_dir, m_addr, m_wdata,
        input  m_ack, m_rdata
    );

    modport slave (
        output i_req, i_addr,
        input  i_ack, i_rdata,
        output d_req, d_dir, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  m_req, m_dir, m_addr, m_wdata,
        output m_ack, m_rdata
    );

endinterface

// File: rtl/bf_mem_arbiter_pick.sv
// bf_arb_pick: decides which client wins when the arbiter leaves IDLE.
// With BF_ARB_RR_EN defined, ties go to the port that was not served last.
// Otherwise the data port always wins ties, and last_grant is ignored.
module bf_arb_pick
    import bf_mem_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_d
);

`ifdef BF_ARB_RR_EN
    // D wins when alone, or on a tie if I was the one served last
    always_comb begin
        grant_d = d_req && (!i_req || (last_grant == GRANT_I));
    end
`else
    logic unused_pick_inputs;

    // D wins whenever it asks; I only gets the memory when D is quiet
    always_comb begin
        unused_pick_inputs = i_req ^ last_grant;
        grant_d            = d_req;
    end
`endif

endmodule

// File: rtl/bf_mem_arbiter.sv
// bf_mem_arbiter: shares one unified memory between the fetch and data ports.
// Only one memory transaction is in flight at a time. Data addresses are
// relocated by d_base and wrap modulo the memory address width.
// BF_ARB_RR_EN selects round-robin tie-breaking. Without it, D has fixed priority.
module bf_mem_arbiter
    import bf_mem_arbiter_pkg::*;
#(
    parameter int          i_addr_width = 16,
    parameter int          d_addr_width = 8,
    parameter int          m_addr_width = 17,
    parameter logic [31:0] d_base       = 32'h10000
) (
    input  logic             clk,
    input  logic             rst_n,
    bf_mem_arbiter_if.master bus
);

    arb_state_t                  state, state_n;
    logic                        granted_d, granted_d_n;
    logic                        m_req_q, m_req_n;
    logic                        m_dir_q, m_dir_n;
    logic [m_addr_width-1:0]     m_addr_q, m_addr_n;
    logic [DATA_WIDTH-1:0]       m_wdata_q, m_wdata_n;
    logic                        i_ack_q, i_ack_n;
    logic                        d_ack_q, d_ack_n;
    logic [DATA_WIDTH-1:0]       i_rdata_q, i_rdata_n;
    logic [DATA_WIDTH-1:0]       d_rdata_q, d_rdata_n;
    logic                        last_grant;
    logic                        pick_grant_d;
    logic                        granted_req;

`ifdef BF_ARB_RR_EN
    logic last_grant_n;

    // Remember which port was served last so the next tie goes to the other
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_D;
        end else begin
            last_grant <= last_grant_n;
        end
    end
`else
    assign last_grant = GRANT_D;
`endif

    bf_arb_pick u_pick (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .last_grant (last_grant),
        .grant_d    (pick_grant_d)
    );

    assign bus.m_req   = m_req_q;
    assign bus.m_dir   = m_dir_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;

    assign granted_req = granted_d ? bus.d_req : bus.i_req;

    // Next-state and next-output logic; every register holds unless a state says otherwise
    always_comb begin
        state_n     = state;
        granted_d_n = granted_d;
        m_req_n     = m_req_q;
        m_dir_n     = m_dir_q;
        m_addr_n    = m_addr_q;
        m_wdata_n   = m_wdata_q;
        i_ack_n     = i_ack_q;
        d_ack_n     = d_ack_q;
        i_rdata_n   = i_rdata_q;
        d_rdata_n   = d_rdata_q;
`ifdef BF_ARB_RR_EN
        last_grant_n = last_grant;
`endif
        case (state)
            ARB_STATE_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    granted_d_n = pick_grant_d;
`ifdef BF_ARB_RR_EN
                    last_grant_n = pick_grant_d;
`endif
                    if (pick_grant_d) begin
                        m_addr_n  = m_addr_width'(d_base) + m_addr_width'(bus.d_addr);
                        m_dir_n   = bus.d_dir;
                        m_wdata_n = bus.d_wdata;
                    end else begin
                        m_addr_n = m_addr_width'(bus.i_addr);
                        m_dir_n  = DIRECTION_READ;
                    end
                    m_req_n = 1'b1;
                    state_n = ARB_STATE_MEM_REQ;
                end
            end
            ARB_STATE_MEM_REQ: begin
                if (bus.m_ack) begin
                    if (granted_d) begin
                        d_rdata_n = bus.m_rdata;
                    end else begin
                        i_rdata_n = bus.m_rdata;
                    end
                    m_req_n = 1'b0;
                    state_n = ARB_STATE_MEM_REL;
                end
            end
            ARB_STATE_MEM_REL: begin
                if (!bus.m_ack) begin
                    if (granted_req) begin
                        if (granted_d) begin
                            d_ack_n = 1'b1;
                        end else begin
                            i_ack_n = 1'b1;
                        end
                        state_n = ARB_STATE_CLI_ACK;
                    end else begin
                        state_n = ARB_STATE_IDLE;
                    end
                end
            end
            ARB_STATE_CLI_ACK: begin
                if (!granted_req) begin
                    i_ack_n = 1'b0;
                    d_ack_n = 1'b0;
                    state_n = ARB_STATE_IDLE;
                end
            end
            default: begin
                state_n = ARB_STATE_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_STATE_IDLE;
            granted_d <= GRANT_I;
            m_req_q   <= 1'b0;
            m_dir_q   <= DIRECTION_READ;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state     <= state_n;
            granted_d <= granted_d_n;
            m_req_q   <= m_req_n;
            m_dir_q   <= m_dir_n;
            m_addr_q  <= m_addr_n;
            m_wdata_q <= m_wdata_n;
            i_ack_q   <= i_ack_n;
            d_ack_q   <= d_ack_n;
            i_rdata_q <= i_rdata_n;
            d_rdata_q <= d_rdata_n;
        end
    end

endmodule
